// File: rtl/can_tx_frame.sv
// rtl/can_tx_frame.sv - CAN 2.0 TX frame serializer: bus-idle wait, SOF, stuffed field, recessive tail and IFS
// Optional arbitration-loss abort enabled by defining CAN_TX_ARB_LOSS_EN.
module can_tx_frame #(
    parameter int clk_speed_MHz    = 100,
    parameter int can_bit_rate_KHz = 1000,
    parameter int SAMPLE_PCT       = 75,
    parameter int MAX_BITS         = 128
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          can_rx,
    input  logic [MAX_BITS-1:0]           tx_bits,
    input  logic [$clog2(MAX_BITS+1)-1:0] tx_len,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic                          arb_lost,
    output logic                          can_tx
);
    localparam int BIT_CLKS = clk_speed_MHz * 1000 / can_bit_rate_KHz;
    localparam int LEN_W    = $clog2(MAX_BITS + 1);
    localparam int TMR_W    = $clog2(BIT_CLKS);
    localparam int IDLE_MAX = 11 * BIT_CLKS;
    localparam int IDLE_W   = $clog2(IDLE_MAX + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_BUS = 3'd1;
    localparam logic [2:0] S_SOF      = 3'd2;
    localparam logic [2:0] S_DATA     = 3'd3;
    localparam logic [2:0] S_TAIL     = 3'd4;
    localparam logic [2:0] S_IFS      = 3'd5;

    logic [2:0]          state;
    logic [TMR_W-1:0]    timer;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [MAX_BITS-1:0] shreg;
    logic [LEN_W-1:0]    remain;
    logic [2:0]          run_len;
    logic [3:0]          seg_cnt;
    logic                bus_idle;
    logic                bit_end;
    logic                timer_run;
    logic                need_stuff;
    logic                arb_abort;

    assign bus_idle   = (idle_cnt == IDLE_W'(IDLE_MAX));
    assign bit_end    = (timer == TMR_W'(BIT_CLKS - 1));
    assign timer_run  = (state != S_IDLE) && (state != S_WAIT_BUS);
    assign need_stuff = (run_len == 3'd5);
    assign tx_ready   = (state == S_IDLE);
    assign tx_busy    = !tx_ready;

    always_ff @(posedge clk) begin
        if (rst || !can_rx) begin
            idle_cnt <= '0;
        end else if (!bus_idle) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

`ifdef CAN_TX_ARB_LOSS_EN
    localparam int SAMPLE_CLK = BIT_CLKS * SAMPLE_PCT / 100 - 1;

    // arb_bits counts unstuffed data bits put on the line, including the current one
    logic [3:0] arb_bits;
    logic       send_data;

    assign send_data = ((state == S_SOF) || (state == S_DATA)) && bit_end
                       && !need_stuff && (remain != '0);
    assign arb_abort = (state == S_DATA) && (arb_bits != 4'd0) && (arb_bits <= 4'd12)
                       && (timer == TMR_W'(SAMPLE_CLK)) && can_tx && !can_rx;

    always_ff @(posedge clk) begin
        if (rst || state == S_IDLE) begin
            arb_bits <= 4'd0;
        end else if (send_data && arb_bits != 4'd13) begin
            arb_bits <= arb_bits + 4'd1;
        end
    end
`else
    assign arb_abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        tx_done  <= 1'b0;
        arb_lost <= 1'b0;
        if (rst) begin
            state   <= S_IDLE;
            can_tx  <= 1'b1;
            timer   <= '0;
            run_len <= 3'd0;
            remain  <= '0;
            seg_cnt <= 4'd0;
            shreg   <= '0;
        end else if (arb_abort) begin
            state    <= S_IDLE;
            can_tx   <= 1'b1;
            arb_lost <= 1'b1;
            timer    <= '0;
        end else begin
            timer <= (timer_run && !bit_end) ? timer + 1'b1 : '0;
            case (state)
                S_IDLE: begin
                    if (tx_valid) begin
                        if (tx_len == '0) begin
                            tx_done <= 1'b1;
                        end else begin
                            state  <= S_WAIT_BUS;
                            shreg  <= tx_bits << (LEN_W'(MAX_BITS) - tx_len);
                            remain <= tx_len;
                        end
                    end
                end
                S_WAIT_BUS: begin
                    if (bus_idle) begin
                        state   <= S_SOF;
                        can_tx  <= 1'b0;
                        run_len <= 3'd1;
                    end
                end
                S_SOF, S_DATA: begin
                    // a stuff bit owed after the last data bit still goes out before the tail
                    if (bit_end) begin
                        if (need_stuff) begin
                            can_tx  <= ~can_tx;
                            run_len <= 3'd1;
                            state   <= S_DATA;
                        end else if (remain != '0) begin
                            can_tx  <= shreg[MAX_BITS-1];
                            shreg   <= shreg << 1;
                            remain  <= remain - 1'b1;
                            run_len <= (shreg[MAX_BITS-1] == can_tx) ? run_len + 3'd1 : 3'd1;
                            state   <= S_DATA;
                        end else begin
                            can_tx  <= 1'b1;
                            seg_cnt <= 4'd0;
                            state   <= S_TAIL;
                        end
                    end
                end
                S_TAIL: begin
                    if (bit_end) begin
                        if (seg_cnt == 4'd9) begin
                            seg_cnt <= 4'd0;
                            state   <= S_IFS;
                        end else begin
                            seg_cnt <= seg_cnt + 4'd1;
                        end
                    end
                end
                S_IFS: begin
                    if (bit_end) begin
                        if (seg_cnt == 4'd2) begin
                            state   <= S_IDLE;
                            tx_done <= 1'b1;
                        end else begin
                            seg_cnt <= seg_cnt + 4'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
